bubble_sort_ctrl: RTL and testbench

BUBBLE_SORT_CTRL -- requirements
Module: bubble_sort_ctrl

---
 rtl/bubble_sort_ctrl.sv | 162 ++++++++++++++++
 tb/tb_bubble_sort_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bubble_sort_ctrl.sv
// Bubble-sort sequencer for an external element datapath: edge-detected load and
// start requests, one compare or swap per cycle, early exit on a pass without swaps.
module bubble_sort_ctrl #(
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_req,
  input  logic             start,
  input  logic             gt,
  output logic             load_en,
  output logic [IDX_W-1:0] load_idx,
  output logic [IDX_W-1:0] cmp_idx,
  output logic             swap_en,
  output logic             busy,
  output logic             done,
  output logic [IDX_W:0]   pass_cnt,
  output logic [7:0]       swap_cnt
);

  localparam int NUM_ELEM = 2**IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_SWAP,
    S_PASS_END,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_load_q;
  logic             r_start_q;
  logic [IDX_W-1:0] r_wr_ptr;
  logic [IDX_W-1:0] w_wr_ptr_next;
  logic [IDX_W-1:0] r_cmp_idx;
  logic [IDX_W-1:0] w_cmp_idx_next;
  logic [IDX_W-1:0] r_limit;
  logic [IDX_W-1:0] w_limit_next;
  logic             r_swapped;
  logic             w_swapped_next;
  logic [IDX_W:0]   r_pass_cnt;
  logic [IDX_W:0]   w_pass_cnt_next;
  logic [7:0]       r_swap_cnt;
  logic [7:0]       w_swap_cnt_next;

  logic             w_load_edge;
  logic             w_start_edge;
  logic             w_last_cmp;

  // load_en is combinational, so the edge is gated by reset to keep it low while held
  assign w_load_edge  = rst_n & load_req & ~r_load_q;
  assign w_start_edge = start & ~r_start_q;
  assign w_last_cmp   = (r_cmp_idx == (r_limit - ONE_IDX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_load_q   <= 1'b0;
      r_start_q  <= 1'b0;
      r_wr_ptr   <= '0;
      r_cmp_idx  <= '0;
      r_limit    <= LAST_IDX;
      r_swapped  <= 1'b0;
      r_pass_cnt <= '0;
      r_swap_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_load_q   <= load_req;
      r_start_q  <= start;
      r_wr_ptr   <= w_wr_ptr_next;
      r_cmp_idx  <= w_cmp_idx_next;
      r_limit    <= w_limit_next;
      r_swapped  <= w_swapped_next;
      r_pass_cnt <= w_pass_cnt_next;
      r_swap_cnt <= w_swap_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_wr_ptr_next   = r_wr_ptr;
    w_cmp_idx_next  = r_cmp_idx;
    w_limit_next    = r_limit;
    w_swapped_next  = r_swapped;
    w_pass_cnt_next = r_pass_cnt;
    w_swap_cnt_next = r_swap_cnt;
    load_en         = 1'b0;
    swap_en         = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        // a load wins over a simultaneous start; the start is dropped, not deferred
        if (w_load_edge) begin
          load_en       = 1'b1;
          w_state_next  = S_IDLE;
          w_wr_ptr_next = r_wr_ptr + ONE_IDX;
        end else if (w_start_edge) begin
          w_state_next    = S_COMPARE;
          w_cmp_idx_next  = '0;
          w_limit_next    = LAST_IDX;
          w_swapped_next  = 1'b0;
          w_pass_cnt_next = '0;
          w_swap_cnt_next = '0;
        end
      end

      S_COMPARE: begin
        if (gt) begin
          w_state_next = S_SWAP;
        end else if (w_last_cmp) begin
          w_state_next   = S_PASS_END;
          w_cmp_idx_next = '0;
        end else begin
          w_cmp_idx_next = r_cmp_idx + ONE_IDX;
        end
      end

      S_SWAP: begin
        swap_en        = 1'b1;
        w_swapped_next = 1'b1;
        if (r_swap_cnt != 8'hFF) begin
          w_swap_cnt_next = r_swap_cnt + 8'd1;
        end
        if (w_last_cmp) begin
          w_state_next   = S_PASS_END;
          w_cmp_idx_next = '0;
        end else begin
          w_state_next   = S_COMPARE;
          w_cmp_idx_next = r_cmp_idx + ONE_IDX;
        end
      end

      S_PASS_END: begin
        w_pass_cnt_next = r_pass_cnt + (IDX_W+1)'(1);
        if (!r_swapped || (r_limit == ONE_IDX)) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next   = S_COMPARE;
          w_limit_next   = r_limit - ONE_IDX;
          w_cmp_idx_next = '0;
          w_swapped_next = 1'b0;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign load_idx = r_wr_ptr;
  assign cmp_idx  = r_cmp_idx;
  assign busy     = (r_state == S_COMPARE) || (r_state == S_SWAP) || (r_state == S_PASS_END);
  assign done     = (r_state == S_DONE);
  assign pass_cnt = r_pass_cnt;
  assign swap_cnt = r_swap_cnt;

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Scoreboarded bench for bubble_sort_ctrl with a 4-element datapath model;
// expected load indices and sort results are queued at stimulus time and popped by a monitor.
module tb_bubble_sort_ctrl;

  localparam int IDX_W   = 2;
  localparam int N       = 4;
  localparam int MAX_LAT = 60;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load_req = 1'b0;
  logic             start = 1'b0;
  logic             gt;
  logic             load_en;
  logic [IDX_W-1:0] load_idx;
  logic [IDX_W-1:0] cmp_idx;
  logic             swap_en;
  logic             busy;
  logic             done;
  logic [IDX_W:0]   pass_cnt;
  logic [7:0]       swap_cnt;

  logic [7:0] load_data = 8'd0;
  logic [7:0] dp [N];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit armed = 1'b0;

  typedef struct packed {
    logic [31:0]     done_cyc;
    logic [31:0]     passes;
    logic [31:0]     swaps;
    logic [3:0][7:0] sorted;
  } exp_t;

  exp_t q_done[$];
  int   q_load[$];
  int   ref_elems[N];
  int   tb_wr = 0;

  bubble_sort_ctrl #(.IDX_W(IDX_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_req (load_req),
    .start    (start),
    .gt       (gt),
    .load_en  (load_en),
    .load_idx (load_idx),
    .cmp_idx  (cmp_idx),
    .swap_en  (swap_en),
    .busy     (busy),
    .done     (done),
    .pass_cnt (pass_cnt),
    .swap_cnt (swap_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // datapath model: writes on load_en, exchanges the compared pair on swap_en
  initial for (int i = 0; i < N; i++) dp[i] = 8'd0;
  always @(posedge clk) begin
    if (load_en) dp[load_idx] <= load_data;
    if (swap_en && (int'(cmp_idx) < N-1)) begin
      dp[cmp_idx]              <= dp[int'(cmp_idx)+1];
      dp[int'(cmp_idx)+1]      <= dp[cmp_idx];
    end
  end
  assign gt = (int'(cmp_idx) < N-1) ? (dp[cmp_idx] > dp[int'(cmp_idx)+1]) : 1'b0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, wanted %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // reference: plain bubble sort with early exit; latency = 1 + per pass (compares + swaps + 1)
  function automatic exp_t model(input int e_cyc);
    exp_t x;
    int a[N];
    int passes = 0;
    int swaps = 0;
    int lat = 1;
    for (int i = 0; i < N; i++) a[i] = ref_elems[i];
    for (int lim = N-1; lim >= 1; lim--) begin
      bit sw = 1'b0;
      for (int j = 0; j < lim; j++) begin
        lat++;
        if (a[j] > a[j+1]) begin
          int t = a[j];
          a[j] = a[j+1];
          a[j+1] = t;
          swaps++;
          lat++;
          sw = 1'b1;
        end
      end
      lat++;
      passes++;
      if (!sw) break;
    end
    x.done_cyc = e_cyc + lat;
    x.passes   = passes;
    x.swaps    = (swaps > 255) ? 255 : swaps;
    for (int i = 0; i < N; i++) begin
      x.sorted[i]  = 8'(a[i]);
      ref_elems[i] = a[i];
    end
    return x;
  endfunction

  // monitor: pops the scoreboard whenever the DUT presents a load strobe or completes a sort
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (load_en) begin
      if (q_load.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_load_en: got load_idx=%0d, wanted no load", load_idx);
      end else begin
        int e;
        e = q_load.pop_front();
        check("load_idx", int'(load_idx), e);
      end
    end
    if (swap_en) begin
      check("swap_with_load", int'(load_en), 0);
      check("swap_armed", int'(armed), 1);
    end
    if (!busy) check("cmp_idx_not_busy", int'(cmp_idx), 0);
    if (done && !prev_done) begin
      if (q_done.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1, wanted no sort completion");
      end else begin
        exp_t x;
        x = q_done.pop_front();
        check("done_cycle", cyc, int'(x.done_cyc));
        check("pass_cnt", int'(pass_cnt), int'(x.passes));
        check("swap_cnt", int'(swap_cnt), int'(x.swaps));
        for (int i = 0; i < N; i++) check("sorted_elem", int'(dp[i]), int'(x.sorted[i]));
      end
    end
    prev_done = done;
  end

  task automatic do_load(input logic [7:0] d);
    @(posedge clk); #1;
    load_req  = 1'b1;
    load_data = d;
    q_load.push_back(tb_wr);
    ref_elems[tb_wr] = d;
    tb_wr = (tb_wr + 1) % N;
    $display("load  data=%0d idx=%0d", d, tb_wr == 0 ? N-1 : tb_wr-1);
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic load_vec(input logic [3:0][7:0] v);
    for (int k = 0; k < N; k++) do_load(v[tb_wr]);
  endtask

  task automatic do_start(output int e);
    exp_t x;
    @(posedge clk); #1;
    start = 1'b1;
    e = cyc;
    armed = 1'b1;
    x = model(e);
    q_done.push_back(x);
    $display("start E=%0d expect passes=%0d swaps=%0d done@%0d", e, x.passes, x.swaps, x.done_cyc);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    for (n = 0; n < MAX_LAT; n++) begin
      @(negedge clk);
      if (done) break;
    end
    total++;
    if (n == MAX_LAT) begin
      bad++;
      $display("FAIL done_timeout: got no done in %0d cycles, wanted done", MAX_LAT);
      q_done.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_load_en"}, int'(load_en), 0);
    check({tag, "_swap_en"}, int'(swap_en), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_cmp_idx"}, int'(cmp_idx), 0);
    check({tag, "_load_idx"}, int'(load_idx), 0);
    check({tag, "_pass_cnt"}, int'(pass_cnt), 0);
    check({tag, "_swap_cnt"}, int'(swap_cnt), 0);
  endtask

  initial begin
    int e;
    int nsw;
    logic [3:0][7:0] v;

    for (int i = 0; i < N; i++) ref_elems[i] = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // loads with wrap-around of the write pointer
    do_load(8'd3);
    do_load(8'd1);
    do_load(8'd4);
    do_load(8'd2);
    do_load(8'd9);

    // already sorted: one pass, no swaps
    v = {8'd4, 8'd3, 8'd2, 8'd1};
    load_vec(v);
    do_start(e);
    wait_done();

    // reversed: three passes, six swaps
    v = {8'd1, 8'd2, 8'd3, 8'd4};
    load_vec(v);
    do_start(e);
    wait_done();

    // requests during a sort are ignored
    load_vec(v);
    do_start(e);
    @(posedge clk);
    @(posedge clk); #1;
    load_req  = 1'b1;
    start     = 1'b1;
    load_data = 8'd77;
    $display("inject load+start at E+3 (expect ignored)");
    @(posedge clk); #1;
    load_req = 1'b0;
    start    = 1'b0;
    wait_done();

    // simultaneous load and start in DONE: load only, back to IDLE
    @(posedge clk); #1;
    load_req  = 1'b1;
    start     = 1'b1;
    load_data = 8'd7;
    q_load.push_back(tb_wr);
    ref_elems[tb_wr] = 7;
    tb_wr = (tb_wr + 1) % N;
    $display("load+start in DONE");
    @(posedge clk); #1;
    load_req = 1'b0;
    start    = 1'b0;
    check("after_dual_done", int'(done), 0);
    check("after_dual_pass_hold", int'(pass_cnt), 3);
    check("after_dual_swap_hold", int'(swap_cnt), 6);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("after_dual_busy", int'(busy), 0);
    end

    // reset in the middle of a sort
    load_vec(v);
    do_start(e);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    armed = 1'b0;
    tb_wr = 0;
    #1;
    $display("reset asserted at E+6");
    check_all_zero("midsort_reset");
    if (q_done.size() > 0) void'(q_done.pop_back());
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    nsw = 0;
    repeat (20) begin
      @(negedge clk);
      if (swap_en) nsw++;
    end
    check("no_swap_after_reset", nsw, 0);

    // randomized arrays
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < N; i++) v[i] = 8'($urandom_range(0, 15));
      load_vec(v);
      do_start(e);
      wait_done();
    end

    // input held high through reset counts as an edge on the first clock
    @(posedge clk); #1;
    rst_n     = 1'b0;
    tb_wr     = 0;
    load_req  = 1'b1;
    load_data = 8'd5;
    @(posedge clk); #1;
    q_load.push_back(0);
    rst_n = 1'b1;
    $display("load_req held through reset release");
    @(posedge clk); #1;
    load_req = 1'b0;
    repeat (3) @(posedge clk);
    check("load_queue_drained", q_load.size(), 0);
    check("done_queue_drained", q_done.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
